tri1_bus_arbiter: RTL

- Parametrised round-robin arbiter for a shared pull-up (tri1-style) 4-state data bus.
- NUM_CH requesters each present a DATA_W-bit 4-state word. One owner is granted at a time and moves bursts onto a registered bus.
- Undriven (z) bits resolve to 1, as a tri1 net does. x/z content is flagged and counted.
- Sits between multi-driver stimulus channels and downstream checkers in the generated-net test infrastructure.

---
 rtl/tri1_bus_pkg.sv | 44 ++++
 rtl/tri1_bus_arbiter_rr_picker.sv | 32 +++
 rtl/tri1_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tri1_bus_pkg.sv
// Shared types and helpers for the tri1 bus arbiter: state encoding,
// owner-index width, and the 4-state resolution and detection functions.
package tri1_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } state_e;

    // Widest data word the helper functions handle. Callers zero-extend
    // their words into this width and cast the result back down.
    localparam int BUS_MAX_W = 64;

    // Width of an index into n items. It is never narrower than one bit.
    function automatic int own_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // tri1 resolution: a floating (z) bit is pulled up to 1, x stays x,
    // and 0/1 pass through. The test for "neither 0 nor 1" comes first,
    // so a simulator that only models two states never takes the pull-up
    // branch for a plain 0.
    function automatic logic [BUS_MAX_W-1:0] resolve_tri1(input logic [BUS_MAX_W-1:0] d);
        logic [BUS_MAX_W-1:0] r;
        r = d;
        for (int i = 0; i < BUS_MAX_W; i++) begin
            if ((d[i] !== 1'b0) && (d[i] !== 1'b1) && (d[i] === 1'bz)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // True when any bit is x or z. The reduction XOR of such a word is x.
    // The result matches ^d === 1'bx, but it is written without an
    // x literal.
    function automatic logic has_xz(input logic [BUS_MAX_W-1:0] d);
        logic p;
        p = ^d;
        return (p !== 1'b0) && (p !== 1'b1);
    endfunction

endpackage

// File: rtl/tri1_bus_arbiter_rr_picker.sv
// Combinational round-robin pick. It scans req starting at ptr+1 and
// wraps modulo NUM_CH. The first set request wins.
module rr_picker
    import tri1_bus_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]           req,
    input  logic [own_w(NUM_CH)-1:0]    ptr,
    output logic                        pick_valid,
    output logic [own_w(NUM_CH)-1:0]    pick_idx
);

    localparam int OWN_W = own_w(NUM_CH);

    // Walk the channels in rotated order. Only the first hit is kept.
    always_comb begin
        // NOTE: every output gets a default before the loop. A path that
        // finds no request then still assigns it, and no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            int c;
            c = (int'(ptr) + i) % NUM_CH;
            if (!pick_valid && req[c]) begin
                pick_valid = 1'b1;
                pick_idx   = OWN_W'(c);
            end
        end
    end

endmodule

// File: rtl/tri1_bus_arbiter.sv
// Round-robin arbiter for a shared pull-up (tri1) 4-state bus. The granted
// channel moves a burst of up to MAX_BURST beats onto a registered bus.
// Floating bits resolve to 1. Words that carry x or z are flagged and
// counted.
module tri1_bus_arbiter
    import tri1_bus_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH-1:0]           last,
    input  logic [DATA_W-1:0]           data_in [NUM_CH],
    output logic [NUM_CH-1:0]           gnt,
    output logic [own_w(NUM_CH)-1:0]    bus_owner,
    output logic [DATA_W-1:0]           bus_data,
    output logic                        bus_valid,
    output logic                        xz_err,
    output logic [CNT_W-1:0]            xz_count
);

    localparam int OWN_W  = own_w(NUM_CH);
    localparam int BEAT_W = own_w(MAX_BURST);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [OWN_W-1:0]  PTR_RST   = OWN_W'(NUM_CH - 1);

    state_e                 state_q, state_d;
    logic [OWN_W-1:0]       ptr_q, ptr_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [OWN_W-1:0]       owner_d;
    logic [NUM_CH-1:0]      gnt_d;
    logic [DATA_W-1:0]      bus_data_d;
    logic                   bus_valid_d;
    logic                   xz_err_d;
    logic [CNT_W-1:0]       xz_count_d;

    logic                   pick_valid;
    logic [OWN_W-1:0]       pick_idx;
    logic [DATA_W-1:0]      raw_word;
    logic [DATA_W-1:0]      resolved_word;
    logic                   raw_is_xz;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_q),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Sample the owner's word, then resolve it and flag any x/z bits.
    always_comb begin
        raw_word      = data_in[bus_owner];
        resolved_word = DATA_W'(resolve_tri1(BUS_MAX_W'(raw_word)));
        raw_is_xz     = has_xz(BUS_MAX_W'(raw_word));
    end

    // Next-state and next-output logic for the IDLE -> XFER -> TURN cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        owner_d     = bus_owner;
        gnt_d       = gnt;
        bus_data_d  = '1;
        bus_valid_d = 1'b0;
        xz_err_d    = 1'b0;
        xz_count_d  = xz_count;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    beat_d          = '0;
                    state_d         = XFER;
                end
            end

            XFER: begin
                if (req[bus_owner]) begin
                    bus_data_d  = resolved_word;
                    bus_valid_d = 1'b1;
                    xz_err_d    = raw_is_xz;
                    if (raw_is_xz && (xz_count != '1)) begin
                        xz_count_d = xz_count + 1'b1;
                    end
                    beat_d = beat_q + 1'b1;
                    // The last-marker and the burst limit may coincide.
                    // Either one ends the burst, and the burst ends once.
                    if (last[bus_owner] || (beat_q == LAST_BEAT)) begin
                        gnt_d   = '0;
                        ptr_d   = bus_owner;
                        state_d = TURN;
                    end
                end else begin
                    // The owner withdrew its request: stop without a beat.
                    gnt_d   = '0;
                    ptr_d   = bus_owner;
                    state_d = TURN;
                end
            end

            TURN: begin
                gnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // All state and registered outputs. A synchronous reset aborts any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register here samples the values from before this edge.
            state_q   <= IDLE;
            ptr_q     <= PTR_RST;
            beat_q    <= '0;
            gnt       <= '0;
            bus_owner <= '0;
            bus_data  <= '1;
            bus_valid <= 1'b0;
            xz_err    <= 1'b0;
            xz_count  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            gnt       <= gnt_d;
            bus_owner <= owner_d;
            bus_data  <= bus_data_d;
            bus_valid <= bus_valid_d;
            xz_err    <= xz_err_d;
            xz_count  <= xz_count_d;
        end
    end

endmodule
